// File: rtl/varredura_sensores_pressao_pkg.sv
// Shared constants, channel map and scan FSM states for the ventilation pressure front-end.
package pacote_ventilacao;

  localparam int unsigned NUM_SENSORES = 7;
  localparam int unsigned LARG_PRES    = 4;
  localparam int unsigned LARG_SEL     = 3;
  localparam int unsigned LARG_QUADRO  = LARG_PRES + 1;

  localparam logic [LARG_SEL-1:0] CANAL_SC    = 3'd0;
  localparam logic [LARG_SEL-1:0] CANAL_S1    = 3'd1;
  localparam logic [LARG_SEL-1:0] CANAL_S2    = 3'd2;
  localparam logic [LARG_SEL-1:0] CANAL_S3    = 3'd3;
  localparam logic [LARG_SEL-1:0] CANAL_TUBSR = 3'd4;
  localparam logic [LARG_SEL-1:0] CANAL_TUBSS = 3'd5;
  localparam logic [LARG_SEL-1:0] CANAL_REA   = 3'd6;

  localparam logic [LARG_PRES-1:0] VALOR_FALHA_PADRAO = 4'b0000;

  typedef enum logic [2:0] {
    OCIOSO,
    SELECIONA,
    AGUARDA,
    DESLOCA,
    VERIFICA,
    PROXIMO,
    COMMIT
  } estado_varredura_t;

endpackage

// File: rtl/varredura_sensores_pressao_receptor.sv
// One-frame serial receiver: generates sensSclk, shifts in 4 data bits plus even parity.
module receptor_serial_sensor
  import pacote_ventilacao::*;
#(
  parameter int unsigned DIV_SCLK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inicia,
  input  logic                 dadoSinc,
  output logic                 sclk,
  output logic                 concluido,
  output logic [LARG_PRES-1:0] dado,
  output logic                 erroParidade
);

  localparam int unsigned LARG_DIV = $clog2(DIV_SCLK);

  logic                   ativo;
  logic [LARG_DIV-1:0]    divCnt;
  logic [2:0]             bitCnt;
  logic [LARG_QUADRO-1:0] desloc;

  // Each half-period lasts DIV_SCLK clocks; a bit is captured on the rising half and
  // the frame ends on the falling edge after the parity bit, leaving sclk low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ativo        <= 1'b0;
      sclk         <= 1'b0;
      divCnt       <= '0;
      bitCnt       <= '0;
      desloc       <= '0;
      concluido    <= 1'b0;
      erroParidade <= 1'b0;
    end else begin
      concluido <= 1'b0;
      if (inicia) begin
        ativo  <= 1'b1;
        sclk   <= 1'b0;
        divCnt <= '0;
        bitCnt <= '0;
      end else if (ativo) begin
        if (divCnt == LARG_DIV'(DIV_SCLK - 1)) begin
          divCnt <= '0;
          sclk   <= ~sclk;
          if (!sclk) begin
            desloc <= {desloc[LARG_QUADRO-2:0], dadoSinc};
          end else if (bitCnt == 3'(LARG_PRES)) begin
            ativo        <= 1'b0;
            concluido    <= 1'b1;
            erroParidade <= ^desloc;
          end else begin
            bitCnt <= bitCnt + 3'd1;
          end
        end else begin
          divCnt <= divCnt + LARG_DIV'(1);
        end
      end
    end
  end

  assign dado = desloc[LARG_QUADRO-1:1];

endmodule

// File: rtl/varredura_sensores_pressao.sv
// Scans seven pressure sensors over a shared serial link and commits all readings atomically.
// Optional macro CONFIRMACAO_LEITURA_EN: a valid value commits only when two consecutive scans agree.
module varredura_sensores_pressao
  import pacote_ventilacao::*;
#(
  parameter int unsigned          DIV_SCLK       = 4,
  parameter int unsigned          TIMEOUT_CICLOS = 64,
  parameter logic [LARG_PRES-1:0] VALOR_FALHA    = VALOR_FALHA_PADRAO
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    habilita,
  output logic [LARG_SEL-1:0]     sensSel,
  output logic                    sensCs,
  output logic                    sensSclk,
  input  logic                    sensDado,
  input  logic                    sensPronto,
  output logic [LARG_PRES-1:0]    sensPresSC,
  output logic [LARG_PRES-1:0]    sensPresS1,
  output logic [LARG_PRES-1:0]    sensPresS2,
  output logic [LARG_PRES-1:0]    sensPresS3,
  output logic [LARG_PRES-1:0]    sensPresTubSR,
  output logic [LARG_PRES-1:0]    sensPresTubSS,
  output logic [LARG_PRES-1:0]    sensPresRea,
  output logic [NUM_SENSORES-1:0] falhaSensor,
  output logic                    varreduraPronta
);

  localparam int unsigned LARG_TMO = $clog2(TIMEOUT_CICLOS);

  estado_varredura_t estado, estadoProx;

  logic                                   dadoMeta, dadoSinc, prontoMeta, prontoSinc;
  logic [LARG_SEL-1:0]                    canal;
  logic [LARG_TMO-1:0]                    tmoCnt;
  logic                                   tmoFalha;
  logic                                   cs;
  logic                                   pronta;
  logic [NUM_SENSORES-1:0][LARG_PRES-1:0] sombra;
  logic [NUM_SENSORES-1:0]                sombraFalha;
  logic [NUM_SENSORES-1:0][LARG_PRES-1:0] pres;
  logic [NUM_SENSORES-1:0]                falhaReg;
  logic                                   iniciaRx_c;
  logic                                   rxConcluido;
  logic                                   rxErro;
  logic [LARG_PRES-1:0]                   rxDado;
  logic                                   quadroFalho;
`ifdef CONFIRMACAO_LEITURA_EN
  logic [NUM_SENSORES-1:0][LARG_PRES-1:0] quadroAnt;
  logic [NUM_SENSORES-1:0]                quadroAntOk;
`endif

  // Two-flop synchronizers for the asynchronous sensor lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dadoMeta   <= 1'b0;
      dadoSinc   <= 1'b0;
      prontoMeta <= 1'b0;
      prontoSinc <= 1'b0;
    end else begin
      dadoMeta   <= sensDado;
      dadoSinc   <= dadoMeta;
      prontoMeta <= sensPronto;
      prontoSinc <= prontoMeta;
    end
  end

  receptor_serial_sensor #(.DIV_SCLK(DIV_SCLK)) uReceptor (
    .clk          (clk),
    .rst          (rst),
    .inicia       (iniciaRx_c),
    .dadoSinc     (dadoSinc),
    .sclk         (sensSclk),
    .concluido    (rxConcluido),
    .dado         (rxDado),
    .erroParidade (rxErro)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado <= OCIOSO;
    else     estado <= estadoProx;
  end

  always_comb begin
    estadoProx = estado;
    iniciaRx_c = 1'b0;
    unique case (estado)
      OCIOSO:    if (habilita) estadoProx = SELECIONA;
      SELECIONA: estadoProx = AGUARDA;
      AGUARDA: begin
        if (prontoSinc) begin
          iniciaRx_c = 1'b1;
          estadoProx = DESLOCA;
        end else if (tmoCnt == LARG_TMO'(TIMEOUT_CICLOS - 1)) begin
          estadoProx = VERIFICA;
        end
      end
      DESLOCA:   if (rxConcluido) estadoProx = VERIFICA;
      VERIFICA:  estadoProx = PROXIMO;
      PROXIMO:   estadoProx = (canal < 3'(NUM_SENSORES - 1)) ? SELECIONA : COMMIT;
      COMMIT:    estadoProx = habilita ? SELECIONA : OCIOSO;
      default:   estadoProx = OCIOSO;
    endcase
  end

  assign quadroFalho = tmoFalha | rxErro;

  // Datapath: timeout tracking, per-channel shadow update and atomic commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      canal       <= '0;
      tmoCnt      <= '0;
      tmoFalha    <= 1'b0;
      cs          <= 1'b0;
      pronta      <= 1'b0;
      sombra      <= {NUM_SENSORES{VALOR_FALHA}};
      sombraFalha <= '1;
      pres        <= {NUM_SENSORES{VALOR_FALHA}};
      falhaReg    <= '1;
`ifdef CONFIRMACAO_LEITURA_EN
      quadroAnt   <= '0;
      quadroAntOk <= '0;
`endif
    end else begin
      cs     <= (estadoProx == SELECIONA) || (estadoProx == AGUARDA) || (estadoProx == DESLOCA);
      pronta <= (estado == COMMIT);
      case (estado)
        SELECIONA: begin
          tmoCnt   <= '0;
          tmoFalha <= 1'b0;
        end
        AGUARDA: begin
          if (!prontoSinc) begin
            if (tmoCnt == LARG_TMO'(TIMEOUT_CICLOS - 1)) tmoFalha <= 1'b1;
            else                                         tmoCnt   <= tmoCnt + LARG_TMO'(1);
          end
        end
        VERIFICA: begin
          if (quadroFalho) begin
            sombra[canal]      <= VALOR_FALHA;
            sombraFalha[canal] <= 1'b1;
`ifdef CONFIRMACAO_LEITURA_EN
            quadroAntOk[canal] <= 1'b0;
`endif
          end else begin
            sombraFalha[canal] <= 1'b0;
`ifdef CONFIRMACAO_LEITURA_EN
            // Unconfirmed values leave the shadow at the last committed reading
            if (quadroAntOk[canal] && (quadroAnt[canal] == rxDado)) sombra[canal] <= rxDado;
            quadroAnt[canal]   <= rxDado;
            quadroAntOk[canal] <= 1'b1;
`else
            sombra[canal] <= rxDado;
`endif
          end
        end
        PROXIMO: begin
          if (canal < 3'(NUM_SENSORES - 1)) canal <= canal + 3'd1;
        end
        COMMIT: begin
          pres     <= sombra;
          falhaReg <= sombraFalha;
          canal    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign sensSel         = canal;
  assign sensCs          = cs;
  assign varreduraPronta = pronta;
  assign falhaSensor     = falhaReg;
  assign sensPresSC      = pres[CANAL_SC];
  assign sensPresS1      = pres[CANAL_S1];
  assign sensPresS2      = pres[CANAL_S2];
  assign sensPresS3      = pres[CANAL_S3];
  assign sensPresTubSR   = pres[CANAL_TUBSR];
  assign sensPresTubSS   = pres[CANAL_TUBSS];
  assign sensPresRea     = pres[CANAL_REA];

endmodule

// File: tb/tb_varredura_sensores_pressao.sv
// Randomized bench for varredura_sensores_pressao with a scan-level reference model.
module tb_varredura_sensores_pressao;

  logic       clk = 1'b0;
  logic       rst;
  logic       habilita;
  logic [2:0] sensSel;
  logic       sensCs, sensSclk, sensDado, sensPronto;
  logic [3:0] sensPresSC, sensPresS1, sensPresS2, sensPresS3;
  logic [3:0] sensPresTubSR, sensPresTubSS, sensPresRea;
  logic [6:0] falhaSensor;
  logic       varreduraPronta;

  int testes = 0;
  int falhas = 0;

  // Sensor bank configuration
  bit         responde [7];
  logic [4:0] quadro   [7];
  int         atrasoResp [7];

  // Reference model state
  logic [3:0] espPres [7];
  logic [6:0] espFalha;
  bit         antOk  [7];
  logic [3:0] antVal [7];

  always #5 clk = ~clk;

  varredura_sensores_pressao dut (
    .clk(clk), .rst(rst), .habilita(habilita),
    .sensSel(sensSel), .sensCs(sensCs), .sensSclk(sensSclk),
    .sensDado(sensDado), .sensPronto(sensPronto),
    .sensPresSC(sensPresSC), .sensPresS1(sensPresS1), .sensPresS2(sensPresS2),
    .sensPresS3(sensPresS3), .sensPresTubSR(sensPresTubSR), .sensPresTubSS(sensPresTubSS),
    .sensPresRea(sensPresRea), .falhaSensor(falhaSensor), .varreduraPronta(varreduraPronta)
  );

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    testes++;
    if (obs !== esp) begin
      falhas++;
      $display("FAIL %s: observado=%h esperado=%h", tag, obs, esp);
    end
  endtask

  function automatic logic [27:0] lePres();
    return {sensPresRea, sensPresTubSS, sensPresTubSR, sensPresS3, sensPresS2, sensPresS1, sensPresSC};
  endfunction

  function automatic logic [27:0] espPresVet();
    logic [27:0] r;
    for (int c = 0; c < 7; c++) r[c*4 +: 4] = espPres[c];
    return r;
  endfunction

  task automatic modeloReset();
    for (int c = 0; c < 7; c++) begin
      espPres[c] = 4'b0000;
      antOk[c]   = 1'b0;
      antVal[c]  = 4'b0000;
    end
    espFalha = 7'h7F;
  endtask

  // What one full scan should commit, given how each sensor behaves
  task automatic modeloScan();
    for (int c = 0; c < 7; c++) begin
      logic [3:0] d;
      bit valido;
      d = quadro[c][4:1];
      valido = responde[c] && ((^quadro[c]) == 1'b0);
      if (!valido) begin
        espPres[c]  = 4'b0000;
        espFalha[c] = 1'b1;
        antOk[c]    = 1'b0;
      end else begin
        espFalha[c] = 1'b0;
`ifdef CONFIRMACAO_LEITURA_EN
        if (antOk[c] && antVal[c] == d) espPres[c] = d;
        antOk[c]  = 1'b1;
        antVal[c] = d;
`else
        espPres[c] = d;
`endif
      end
    end
  endtask

  // Behavioural sensor: raises ready after a delay, shifts a new bit after each sclk fall
  initial begin
    bit   ativo = 0;
    bit   sclkAnt = 0;
    int   atraso = 0;
    int   bitIdx = 0;
    int   sel = 0;
    sensPronto = 1'b0;
    sensDado   = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!sensCs) begin
        ativo = 0;
        sensPronto = 1'b0;
        sensDado = 1'b0;
      end else begin
        if (!ativo) begin
          ativo = 1;
          sel = int'(sensSel);
          atraso = atrasoResp[sel];
          bitIdx = 0;
        end
        if (responde[sel] && !sensPronto) begin
          if (atraso > 0) atraso--;
          else begin
            sensPronto = 1'b1;
            sensDado = quadro[sel][4];
          end
        end else if (sensPronto && sclkAnt && !sensSclk) begin
          bitIdx++;
          if (bitIdx < 5) sensDado = quadro[sel][4 - bitIdx];
        end
      end
      sclkAnt = sensSclk;
    end
  end

  task automatic esperaCanal(input logic [2:0] c, input string tag);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (sensCs && sensSel == c) begin ok = 1; break; end
    end
    if (!ok) confere({tag, "_espera"}, 32'd0, 32'd1);
  endtask

  // Counts commits until the design idles and checks the first one against the model
  task automatic esperaCommit(input string tag);
    int n = 0;
    int ultimo = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (varreduraPronta) begin
        n++;
        ultimo = i;
        if (n == 1) begin
          confere({tag, "_pres"}, 32'(lePres()), 32'(espPresVet()));
          confere({tag, "_falha"}, 32'(falhaSensor), 32'(espFalha));
        end
      end
      if (n > 0 && i > ultimo + 60) break;
    end
    confere({tag, "_commits"}, 32'(n), 32'd1);
    confere({tag, "_csOcioso"}, 32'(sensCs), 32'd0);
  endtask

  task automatic rodaScan(input string tag, input logic [2:0] canalSolta);
    habilita = 1'b1;
    esperaCanal(canalSolta, tag);
    habilita = 1'b0;
    modeloScan();
    esperaCommit(tag);
  endtask

  task automatic configPlano();
    quadro[0] = 5'b01010; quadro[1] = 5'b10001; quadro[2] = 5'b00110;
    quadro[3] = 5'b11110; quadro[4] = 5'b00011; quadro[5] = 5'b01100;
    quadro[6] = 5'b10100;
    for (int c = 0; c < 7; c++) begin
      responde[c] = 1'b1;
      atrasoResp[c] = int'($urandom_range(0, 5));
    end
  endtask

  task automatic checaReset(input string tag);
    confere({tag, "_pres"}, 32'(lePres()), 32'd0);
    confere({tag, "_falha"}, 32'(falhaSensor), 32'h7F);
    confere({tag, "_cs"}, 32'(sensCs), 32'd0);
    confere({tag, "_sel"}, 32'(sensSel), 32'd0);
    confere({tag, "_sclk"}, 32'(sensSclk), 32'd0);
    confere({tag, "_pronta"}, 32'(varreduraPronta), 32'd0);
  endtask

  initial begin
    bit achou;
    rst = 1'b1;
    habilita = 1'b0;
    configPlano();
    modeloReset();
    repeat (3) @(posedge clk);
    #1;
    checaReset("reset");
    rst = 1'b0;

    rodaScan("plano", 3'd6);

    responde[3] = 1'b0;
    rodaScan("timeoutS3", 3'd3);
    responde[3] = 1'b1;

    quadro[5] = 5'b01101;
    rodaScan("paridadeTubSS", 3'd2);
    quadro[5] = 5'b01100;
    rodaScan("recupera", 3'd1);

    quadro[6] = 5'b01111; rodaScan("rea0111a", 3'd0);
    quadro[6] = 5'b01111; rodaScan("rea0111b", 3'd4);
    quadro[6] = 5'b01001; rodaScan("rea0100", 3'd5);

    // Asynchronous reset while channel 4 is shifting
    configPlano();
    habilita = 1'b1;
    achou = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (sensSel == 3'd4 && sensSclk) begin achou = 1; break; end
    end
    confere("rstDesloca_espera", 32'(achou), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    modeloReset();
    checaReset("rstDesloca");
    @(posedge clk); #1;
    rst = 1'b0;
    achou = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (sensCs) begin achou = 1; break; end
    end
    confere("rstRecomeco_cs", 32'(achou), 32'd1);
    confere("rstRecomeco_sel", 32'(sensSel), 32'd0);
    habilita = 1'b0;
    modeloScan();
    esperaCommit("rstRecomeco");

    // Random frames, dead sensors and parity corruption
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 7; c++) begin
        logic [3:0] d;
        d = 4'($urandom_range(0, 15));
        quadro[c] = {d, ^d ^ ($urandom_range(0, 5) == 0)};
        responde[c] = ($urandom_range(0, 7) != 0);
        atrasoResp[c] = int'($urandom_range(0, 5));
      end
      if (k % 3 == 0) for (int c = 0; c < 7; c++) quadro[c] = quadro[c];
      rodaScan($sformatf("aleat%0d", k), 3'($urandom_range(0, 6)));
    end

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule

// File: doc/varredura_sensores_pressao.md
Name: varredura_sensores_pressao

Overview:
- Acquisition front-end feeding the ventilation damper logic.
- Scans the seven 4-bit two's-complement pressure sensors over a shared multiplexed serial link, checks each frame, and presents registered readings.
- Outputs are SC, S1, S2, S3, TubSR, TubSS and Rea, together with per-sensor fault flags.
- Readings commit atomically once per complete scan, so downstream combinational damper logic never sees a mixed scan.

Parameters:
- DIV_SCLK, 4: clk cycles per sensSclk half-period (>=2).
- TIMEOUT_CICLOS, 64: max clk cycles waiting for sensPronto after select.
- VALOR_FALHA, 4'b0000: fail-safe value for a faulted channel and for reset.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- habilita  in  1  continuous scanning enable
- sensSel  out  3  sensor mux address (0=SC, 1=S1, 2=S2, 3=S3, 4=TubSR, 5=TubSS, 6=Rea)
- sensCs  out  1  sensor chip-select, active-high
- sensSclk  out  1  serial clock
- sensDado  in  1  serial data, MSB first
- sensPronto  in  1  sensor ready
- sensPresSC, sensPresS1, sensPresS2, sensPresS3, sensPresTubSR, sensPresTubSS, sensPresRea  out  4 each  committed readings
- falhaSensor  out  7  per-channel fault from the last committed scan; bit index = sensSel code
- varreduraPronta  out  1  one-cycle pulse on each commit

Behaviour:
- Reset (async, immediate):
  - FSM to OCIOSO; sensSel=0, sensCs=0, sensSclk=0, varreduraPronta=0.
  - All sensPres* = VALOR_FALHA; falhaSensor = 7'h7F.
  - Shadow registers are cleared the same way.
- Synchronization: sensDado and sensPronto pass through 2-flop synchronizers; all decisions use the synchronized copies.
- FSM:
  - OCIOSO: go to SELECIONA when habilita=1, with channel=0.
  - SELECIONA (1 cycle): drive sensSel=channel, sensCs=1, sensSclk=0, clear timeout counter.
  - AGUARDA: go to DESLOCA on synchronized sensPronto=1. If the counter reaches TIMEOUT_CICLOS, mark a timeout fault and go to VERIFICA.
  - DESLOCA: 5 sensSclk periods (DIV_SCLK low, then DIV_SCLK high). Sample synchronized sensDado on the clk edge where sensSclk rises. The first 4 bits are data (MSB first); the 5th is even parity over the data.
  - VERIFICA (1 cycle):
    - Valid frame: shadow[channel] = data, shadowFalha[channel] = 0.
    - Timeout or parity error: shadow[channel] = VALOR_FALHA, shadowFalha[channel] = 1.
    - Drop sensCs.
  - PROXIMO (1 cycle): if channel<6, increment channel and go to SELECIONA; else go to COMMIT.
  - COMMIT (1 cycle): copy all shadows to sensPres* and falhaSensor, pulse varreduraPronta. Next state is SELECIONA (channel=0) if habilita=1, else OCIOSO.
- habilita deasserted mid-scan: the current scan completes and commits, then OCIOSO. Outputs hold their last values while idle.
- Channel timing, valid frame: 1 + (2 sync + wait) + 10*DIV_SCLK + 2 cycles.
- sensSclk returns low before VERIFICA. sensCs stays low for at least 2 cycles between channels.
- Data values are opaque 4-bit codes; no arithmetic is applied.

Optional Feature:
- Macro: CONFIRMACAO_LEITURA_EN.
- Defined:
  - A per-channel previous-frame register is kept.
  - A valid channel value commits only if it equals the previous scan's valid frame. Otherwise the prior committed value is held, falha=0, and the previous-frame register is updated.
  - A fault still forces VALOR_FALHA immediately.
  - The first valid scan after reset commits VALOR_FALHA with falha=0.
- Undefined: every valid frame commits directly.

Decomposition:
- Package pacote_ventilacao holds:
  - channel index constants CANAL_SC..CANAL_REA (0..6);
  - NUM_SENSORES=7 and LARG_PRES=4;
  - FSM state enum estado_varredura_t;
  - default VALOR_FALHA.
- Sub-module receptor_serial_sensor: sensSclk generation, 5-bit shift and parity check for one frame. It has start/done handshake and outputs dado[3:0], erroParidade.

Test Plan:
- All sensors respond within 5 cycles. Frames: SC=0101 p0, S1=1000 p1, S2=0011 p0, S3=1111 p0, TubSR=0001 p1, TubSS=0110 p0, Rea=1010 p0. Required: one varreduraPronta pulse, outputs match, falhaSensor=0.
- S3 never raises sensPronto. Required: sensPresS3=0000 and falhaSensor=7'b0001000 after TIMEOUT_CICLOS; other channels valid.
- TubSS frame 0110 with parity 1. Required: sensPresTubSS=0000, falhaSensor[5]=1; the next good scan clears it.
- rst asserted during DESLOCA of channel 4. Required: outputs immediately return to reset values; the next scan starts at sensSel=0 after rst release.
- habilita dropped during channel 2. Required: scan finishes, exactly one commit, FSM idles with sensCs=0.
- With CONFIRMACAO_LEITURA_EN, Rea reads 0111, 0111, 0100. Required: commits 0000, 0111, 0111.
